alu_arb: RTL

ALU_ARB -- requirements
Module: alu_arb

---
 rtl/alu_arb.sv | 110 +++++++++++
 1 files changed

// File: rtl/alu_arb.sv
// Two-requester round-robin front end for a shared ALU: latches the winner's
// operands, strobes the ALU, waits out its latency and returns the result.
module alu_arb #(
  parameter int MUL_LAT = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] ir0,
  input  logic [15:0] ir1,
  input  logic [15:0] a0,
  input  logic [15:0] a1,
  input  logic [15:0] b0,
  input  logic [15:0] b1,
  input  logic [15:0] pc0,
  input  logic [15:0] pc1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] res,
  output logic        busy,
  output logic        alu_load,
  output logic [15:0] alu_ir,
  output logic [15:0] alu_sr1,
  output logic [15:0] alu_sr2,
  output logic [15:0] alu_pc,
  input  logic [15:0] alu_q
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       owner;
  logic       last;
  logic       pick;
  logic       is_mul;

  // On a tie the requester that was not served last wins.
  always_comb begin
    pick   = req1 & (~req0 | ~last);
    is_mul = (alu_ir[15:14] == 2'b00) && (alu_ir[4:0] == 5'b00011);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the one-cycle strobes default low each edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      cnt      <= '0;
      owner    <= 1'b0;
      last     <= 1'b1;
      res      <= '0;
      busy     <= 1'b0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      alu_load <= 1'b0;
      alu_ir   <= '0;
      alu_sr1  <= '0;
      alu_sr2  <= '0;
      alu_pc   <= '0;
    end else begin
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      alu_load <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner    <= pick;
            alu_ir   <= pick ? ir1 : ir0;
            alu_sr1  <= pick ? a1  : a0;
            alu_sr2  <= pick ? b1  : b0;
            alu_pc   <= pick ? pc1 : pc0;
            gnt0     <= ~pick;
            gnt1     <= pick;
            alu_load <= 1'b1;
            busy     <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= is_mul ? MUL_CNT : 4'd0;
          state <= WAIT;
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            res   <= alu_q;
            done0 <= ~owner;
            done1 <= owner;
            last  <= owner;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
